// File: rtl/sprite_color_mapper.sv
`default_nettype none
// ============================================================================
// Module   : sprite_color_mapper
// Brief    : Three-stage pixel colour mapper. Each pixel is tested against
//            NUM_OBJ rectangle/ellipse objects whose geometry is latched once
//            per frame. The lowest-index hit wins, and a per-object blink
//            counter flashes the winning object white for damage feedback.
// Option   : define SPRITE_MAPPER_GRADIENT_EN for a blue horizontal gradient
//            background instead of black.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_color_mapper #(
  parameter int NUM_OBJ      = 4,
  parameter int COORD_W      = 10,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         frame_start,
  input  logic                         pix_valid,
  input  logic [COORD_W-1:0]           DrawX,
  input  logic [COORD_W-1:0]           DrawY,
  input  logic [NUM_OBJ*COORD_W-1:0]   ObjX,
  input  logic [NUM_OBJ*COORD_W-1:0]   ObjY,
  input  logic [NUM_OBJ*COORD_W-1:0]   ObjSizeX,
  input  logic [NUM_OBJ*COORD_W-1:0]   ObjSizeY,
  input  logic [NUM_OBJ-1:0]           obj_shape,
  input  logic [NUM_OBJ-1:0]           obj_en,
  input  logic [NUM_OBJ*24-1:0]        obj_rgb,
  input  logic [NUM_OBJ-1:0]           flash_req,
  output logic [7:0]                   Red,
  output logic [7:0]                   Green,
  output logic [7:0]                   Blue,
  output logic                         out_valid,
  output logic [$clog2(NUM_OBJ):0]     hit_id
);

  localparam int c_id_w   = $clog2(NUM_OBJ) + 1;
  localparam int c_cnt_w  = $clog2(BLINK_FRAMES + 1);
  localparam int c_prod_w = 4 * COORD_W + 4;
  localparam logic [c_id_w-1:0]  c_bg_id      = '1;
  localparam logic [c_cnt_w-1:0] c_blink_load = c_cnt_w'(BLINK_FRAMES);
  localparam logic [23:0]        c_white      = 24'hFFFFFF;

  // Per-frame shadow copy of the object description
  logic [COORD_W-1:0]        r_sh_x     [NUM_OBJ];
  logic [COORD_W-1:0]        r_sh_y     [NUM_OBJ];
  logic [COORD_W-1:0]        r_sh_sx    [NUM_OBJ];
  logic [COORD_W-1:0]        r_sh_sy    [NUM_OBJ];
  logic [23:0]               r_sh_rgb   [NUM_OBJ];
  logic [NUM_OBJ-1:0]        r_sh_shape;
  logic [NUM_OBJ-1:0]        r_sh_en;
  logic [c_cnt_w-1:0]        r_blink_cnt [NUM_OBJ];

  // Pipeline state
  logic signed [COORD_W:0]   r_s1_dx [NUM_OBJ];
  logic signed [COORD_W:0]   r_s1_dy [NUM_OBJ];
  logic                      r_s1_valid;
  logic [NUM_OBJ-1:0]        r_s2_hit;
  logic                      r_s2_valid;
`ifdef SPRITE_MAPPER_GRADIENT_EN
  logic [6:0]                r_s1_gx;
  logic [6:0]                r_s2_gx;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
      logic [COORD_W:0]     w_adx;
      logic [COORD_W:0]     w_ady;
      logic [COORD_W+1:0]   w_2dx;
      logic [COORD_W+1:0]   w_2dy;
      logic [c_prod_w-1:0]  w_tx;
      logic [c_prod_w-1:0]  w_ty;
      logic [c_prod_w-1:0]  w_sx2;
      logic [c_prod_w-1:0]  w_sy2;
      logic                 w_rect_hit;
      logic                 w_ell_hit;
      logic                 w_hit;

      // Latch object description at frame start so geometry never tears mid-frame
      always_ff @(posedge Clk) begin
        if (Reset) begin
          r_sh_x[gi]     <= '0;
          r_sh_y[gi]     <= '0;
          r_sh_sx[gi]    <= '0;
          r_sh_sy[gi]    <= '0;
          r_sh_rgb[gi]   <= '0;
          r_sh_shape[gi] <= 1'b0;
          r_sh_en[gi]    <= 1'b0;
        end else if (frame_start) begin
          r_sh_x[gi]     <= ObjX[gi*COORD_W +: COORD_W];
          r_sh_y[gi]     <= ObjY[gi*COORD_W +: COORD_W];
          r_sh_sx[gi]    <= ObjSizeX[gi*COORD_W +: COORD_W];
          r_sh_sy[gi]    <= ObjSizeY[gi*COORD_W +: COORD_W];
          r_sh_rgb[gi]   <= obj_rgb[gi*24 +: 24];
          r_sh_shape[gi] <= obj_shape[gi];
          r_sh_en[gi]    <= obj_en[gi];
        end
      end

      // Blink counter: a flash request (re)loads, each frame start counts down
      always_ff @(posedge Clk) begin
        if (Reset) begin
          r_blink_cnt[gi] <= '0;
        end else if (flash_req[gi]) begin
          r_blink_cnt[gi] <= c_blink_load;
        end else if (frame_start && (r_blink_cnt[gi] != '0)) begin
          r_blink_cnt[gi] <= r_blink_cnt[gi] - 1'b1;
        end
      end

      // S1: signed offset of the pixel from the object centre (one extra bit, no wrap)
      always_ff @(posedge Clk) begin
        if (Reset) begin
          r_s1_dx[gi] <= '0;
          r_s1_dy[gi] <= '0;
        end else begin
          r_s1_dx[gi] <= $signed({1'b0, DrawX}) - $signed({1'b0, r_sh_x[gi]});
          r_s1_dy[gi] <= $signed({1'b0, DrawY}) - $signed({1'b0, r_sh_y[gi]});
        end
      end

      // S2 combinational: rectangle and full-precision ellipse containment tests
      always_comb begin
        w_adx      = r_s1_dx[gi][COORD_W] ? -r_s1_dx[gi] : r_s1_dx[gi];
        w_ady      = r_s1_dy[gi][COORD_W] ? -r_s1_dy[gi] : r_s1_dy[gi];
        w_2dx      = {w_adx, 1'b0};
        w_2dy      = {w_ady, 1'b0};
        w_rect_hit = (w_2dx <= {2'b00, r_sh_sx[gi]}) && (w_2dy <= {2'b00, r_sh_sy[gi]});
        w_tx       = c_prod_w'(w_2dx) * c_prod_w'(w_2dx);
        w_ty       = c_prod_w'(w_2dy) * c_prod_w'(w_2dy);
        w_sx2      = c_prod_w'(r_sh_sx[gi]) * c_prod_w'(r_sh_sx[gi]);
        w_sy2      = c_prod_w'(r_sh_sy[gi]) * c_prod_w'(r_sh_sy[gi]);
        w_ell_hit  = (w_tx * w_sy2 + w_ty * w_sx2) <= (w_sx2 * w_sy2);
        w_hit      = r_sh_en[gi] && (r_sh_sx[gi] != '0) && (r_sh_sy[gi] != '0) &&
                     (r_sh_shape[gi] ? w_ell_hit : w_rect_hit);
      end

      // S2 register: per-object hit flag
      always_ff @(posedge Clk) begin
        if (Reset) begin
          r_s2_hit[gi] <= 1'b0;
        end else begin
          r_s2_hit[gi] <= w_hit;
        end
      end
    end
  endgenerate

  // Carry pixel-valid (and the gradient column, when enabled) alongside the hit tests
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
`ifdef SPRITE_MAPPER_GRADIENT_EN
      r_s1_gx    <= '0;
      r_s2_gx    <= '0;
`endif
    end else begin
      r_s1_valid <= pix_valid;
      r_s2_valid <= r_s1_valid;
`ifdef SPRITE_MAPPER_GRADIENT_EN
      r_s1_gx    <= DrawX[9:3];
      r_s2_gx    <= r_s1_gx;
`endif
    end
  end

  logic [23:0]       w_bg_rgb;
  logic [23:0]       w_rgb;
  logic [c_id_w-1:0] w_id;

  // S3 combinational: background, then lowest-index hit overrides (scan high to low)
  always_comb begin
`ifdef SPRITE_MAPPER_GRADIENT_EN
    w_bg_rgb = {16'h0000, 8'h7F - {1'b0, r_s2_gx}};
`else
    w_bg_rgb = 24'h000000;
`endif
    w_rgb = w_bg_rgb;
    w_id  = c_bg_id;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (r_s2_hit[i]) begin
        w_id  = c_id_w'(i);
        w_rgb = ((r_blink_cnt[i] != '0) && r_blink_cnt[i][0]) ? c_white : r_sh_rgb[i];
      end
    end
  end

  // S3 register: blank colour and background id whenever the pixel is not visible
  always_ff @(posedge Clk) begin
    if (Reset || !r_s2_valid) begin
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
      out_valid <= 1'b0;
      hit_id    <= c_bg_id;
    end else begin
      Red       <= w_rgb[23:16];
      Green     <= w_rgb[15:8];
      Blue      <= w_rgb[7:0];
      out_valid <= 1'b1;
      hit_id    <= w_id;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_color_mapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_color_mapper
// Brief    : Directed self-checking bench for sprite_color_mapper.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_color_mapper;

  localparam int NUM_OBJ = 4;
  localparam int COORD_W = 10;

  logic                       Clk = 1'b0;
  logic                       Reset;
  logic                       frame_start;
  logic                       pix_valid;
  logic [COORD_W-1:0]         DrawX;
  logic [COORD_W-1:0]         DrawY;
  logic [NUM_OBJ*COORD_W-1:0] ObjX;
  logic [NUM_OBJ*COORD_W-1:0] ObjY;
  logic [NUM_OBJ*COORD_W-1:0] ObjSizeX;
  logic [NUM_OBJ*COORD_W-1:0] ObjSizeY;
  logic [NUM_OBJ-1:0]         obj_shape;
  logic [NUM_OBJ-1:0]         obj_en;
  logic [NUM_OBJ*24-1:0]      obj_rgb;
  logic [NUM_OBJ-1:0]         flash_req;
  logic [7:0]                 Red;
  logic [7:0]                 Green;
  logic [7:0]                 Blue;
  logic                       out_valid;
  logic [2:0]                 hit_id;

  int checks   = 0;
  int failures = 0;

  sprite_color_mapper #(
    .NUM_OBJ      (NUM_OBJ),
    .COORD_W      (COORD_W),
    .BLINK_FRAMES (8)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .ObjX        (ObjX),
    .ObjY        (ObjY),
    .ObjSizeX    (ObjSizeX),
    .ObjSizeY    (ObjSizeY),
    .obj_shape   (obj_shape),
    .obj_en      (obj_en),
    .obj_rgb     (obj_rgb),
    .flash_req   (flash_req),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue),
    .out_valid   (out_valid),
    .hit_id      (hit_id)
  );

  always #5 Clk = ~Clk;

  // Expected background colour for a visible pixel at column x
  function automatic logic [23:0] bg(input logic [9:0] x);
`ifdef SPRITE_MAPPER_GRADIENT_EN
    return {16'h0000, 8'h7F - {1'b0, x[9:3]}};
`else
    return 24'h000000 | {14'd0, x & 10'd0};
`endif
  endfunction

  task automatic check(input string tag, input logic [23:0] exp_rgb,
                       input logic [2:0] exp_id, input logic exp_valid);
    checks++;
    assert ({Red, Green, Blue} === exp_rgb && hit_id === exp_id && out_valid === exp_valid)
    else begin
      failures++;
      $error("FAIL %s observed rgb=%h id=%0d valid=%b expected rgb=%h id=%0d valid=%b",
             tag, {Red, Green, Blue}, hit_id, out_valid, exp_rgb, exp_id, exp_valid);
    end
  endtask

  // Present one pixel and wait until its result has left the pipeline
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic v);
    DrawX = x; DrawY = y; pix_valid = v;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic fstart();
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic flash(input logic [3:0] m, input logic with_fs);
    flash_req = m; frame_start = with_fs;
    @(posedge Clk); #1;
    flash_req = '0; frame_start = 1'b0;
  endtask

  task automatic set_obj(input int i, input logic [9:0] x, input logic [9:0] y,
                         input logic [9:0] sx, input logic [9:0] sy,
                         input logic shp, input logic en, input logic [23:0] rgb);
    ObjX[i*COORD_W +: COORD_W]     = x;
    ObjY[i*COORD_W +: COORD_W]     = y;
    ObjSizeX[i*COORD_W +: COORD_W] = sx;
    ObjSizeY[i*COORD_W +: COORD_W] = sy;
    obj_shape[i] = shp;
    obj_en[i]    = en;
    obj_rgb[i*24 +: 24] = rgb;
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; DrawX = '0; DrawY = '0;
    ObjX = '0; ObjY = '0; ObjSizeX = '0; ObjSizeY = '0;
    obj_shape = '0; obj_en = '0; obj_rgb = '0; flash_req = '0;

    // Reset state
    repeat (2) @(posedge Clk); #1;
    check("reset", 24'h000000, 3'd7, 1'b0);
    Reset = 1'b0;

    // No frame_start yet: shadows empty, background only
    set_obj(0, 10'd100, 10'd100, 10'd20, 10'd10, 1'b0, 1'b1, 24'hFF5500);
    pix(10'd110, 10'd105, 1'b1);
    check("no_frame_bg", bg(10'd110), 3'd7, 1'b1);
    pix(10'd0, 10'd0, 1'b1);
    check("bg_col0", bg(10'd0), 3'd7, 1'b1);
    pix(10'd110, 10'd105, 1'b0);
    check("invalid_pix", 24'h000000, 3'd7, 1'b0);

    // Rectangle edges
    fstart();
    pix(10'd110, 10'd105, 1'b1);
    check("rect_corner", 24'hFF5500, 3'd0, 1'b1);
    pix(10'd111, 10'd105, 1'b1);
    check("rect_x_out", bg(10'd111), 3'd7, 1'b1);
    pix(10'd90, 10'd95, 1'b1);
    check("rect_neg_corner", 24'hFF5500, 3'd0, 1'b1);
    pix(10'd100, 10'd106, 1'b1);
    check("rect_y_out", bg(10'd100), 3'd7, 1'b1);

    // Ellipse
    set_obj(1, 10'd200, 10'd200, 10'd40, 10'd40, 1'b1, 1'b1, 24'h0000CC);
    fstart();
    pix(10'd220, 10'd200, 1'b1);
    check("ell_edge", 24'h0000CC, 3'd1, 1'b1);
    pix(10'd221, 10'd200, 1'b1);
    check("ell_x_out", bg(10'd221), 3'd7, 1'b1);
    pix(10'd214, 10'd213, 1'b1);
    check("ell_diag_in", 24'h0000CC, 3'd1, 1'b1);
    pix(10'd215, 10'd215, 1'b1);
    check("ell_diag_out", bg(10'd215), 3'd7, 1'b1);
    pix(10'd220, 10'd220, 1'b1);
    check("ell_corner_out", bg(10'd220), 3'd7, 1'b1);

    // Priority
    set_obj(0, 10'd300, 10'd300, 10'd10, 10'd10, 1'b0, 1'b1, 24'hFF5500);
    set_obj(2, 10'd300, 10'd300, 10'd20, 10'd20, 1'b0, 1'b1, 24'h00FF00);
    fstart();
    pix(10'd300, 10'd300, 1'b1);
    check("prio_obj0", 24'hFF5500, 3'd0, 1'b1);
    obj_en[0] = 1'b0;
    fstart();
    pix(10'd300, 10'd300, 1'b1);
    check("prio_obj2", 24'h00FF00, 3'd2, 1'b1);
    obj_en[0] = 1'b1;
    fstart();

    // Blink: counter 8 after load (even -> normal), odd frames white, normal after 8th
    flash(4'b0001, 1'b0);
    pix(10'd300, 10'd300, 1'b1);
    check("blink_load", 24'hFF5500, 3'd0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      fstart();
      pix(10'd300, 10'd300, 1'b1);
      check($sformatf("blink_f%0d", k), (k % 2 == 1) ? 24'hFFFFFF : 24'hFF5500, 3'd0, 1'b1);
    end
    // Load wins over simultaneous frame_start: count 8 then 7
    flash(4'b0001, 1'b1);
    pix(10'd300, 10'd300, 1'b1);
    check("blink_load_fs", 24'hFF5500, 3'd0, 1'b1);
    fstart();
    pix(10'd300, 10'd300, 1'b1);
    check("blink_after_fs", 24'hFFFFFF, 3'd0, 1'b1);
    // Reload while blinking restarts at 8
    flash(4'b0001, 1'b0);
    pix(10'd300, 10'd300, 1'b1);
    check("blink_reload", 24'hFF5500, 3'd0, 1'b1);
    fstart();
    pix(10'd300, 10'd300, 1'b1);
    check("blink_reload_f1", 24'hFFFFFF, 3'd0, 1'b1);
    repeat (7) fstart();

    // Mid-frame object move is invisible until next frame_start
    ObjX[0 +: COORD_W] = 10'd400;
    pix(10'd300, 10'd300, 1'b1);
    check("midframe_hold", 24'hFF5500, 3'd0, 1'b1);
    fstart();
    pix(10'd300, 10'd300, 1'b1);
    check("midframe_apply", 24'h00FF00, 3'd2, 1'b1);

    // Reset mid-frame clears shadows until the next frame_start
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    pix(10'd300, 10'd300, 1'b1);
    check("reset_midframe", bg(10'd300), 3'd7, 1'b1);
    fstart();
    pix(10'd300, 10'd300, 1'b1);
    check("after_reset_frame", 24'h00FF00, 3'd2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
